uart_receiver: RTL and testbench

UART 8N1 receiver with ×16 oversampling. It pairs with the existing serial transmitter on the same baud/sample-tick infrastructure.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at its midpoint and reassembles the byte LSB first.
- Checks the stop bit and flags framing errors.
- Delivers each byte with a one-cycle done pulse to the command/host logic on the FPGA.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: FSM state encodings
// and default frame geometry.
package uart_pkg;

    // Encodings match the transmitter so both FSMs read the same in waveforms.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_STOP  = 2'b11
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to
// ResetVal so an idle-high line does not glitch out of reset.
module uart_sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver with sample_tick oversampling: synchronises rx, samples each
// bit at its midpoint LSB first, checks the stop bit and pulses rx_done_tick.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = UART_DATA_BITS,
    parameter int unsigned STOP_BIT_TICK = UART_OVERSAMPLE
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_busy,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [3:0]         MidStartTick = 4'(STOP_BIT_TICK / 2 - 1);
    localparam logic [3:0]         LastTick     = 4'(STOP_BIT_TICK - 1);
    localparam logic [BitCntW-1:0] LastBit      = BitCntW'(DATA_BITS - 1);

    if ((STOP_BIT_TICK < 4) || (STOP_BIT_TICK > 16) || (STOP_BIT_TICK % 2 != 0)) begin : g_bad_tick
        $error("uart_receiver: STOP_BIT_TICK must be even and within 4..16");
    end
    if (DATA_BITS < 1) begin : g_bad_bits
        $error("uart_receiver: DATA_BITS must be at least 1");
    end

    logic rx_s;

    uart_sync_2ff #(
        .ResetVal(1'b1)
    ) u_rx_sync (
        .clk_i(clk_50MHz),
        .rst_i(reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [BitCntW-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;

        unique case (state_q)
            // Idle watches the line every clock so a start right after a stop is not missed.
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end

            S_START: begin
                if (sample_tick) begin
                    if (tick_q == MidStartTick) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (sample_tick) begin
                    if (tick_q == LastTick) begin
                        tick_d  = '0;
                        shreg_d = DATA_BITS'({rx_s, shreg_q} >> 1);
                        if (bit_q == LastBit) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + BitCntW'(1);
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            S_STOP: begin
                if (sample_tick) begin
                    if (tick_q == LastTick) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                        data_d  = shreg_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '1;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out     = data_q;
    assign rx_busy      = busy_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: serial frames driven at 16 x 27 clocks per
// bit, completed frames captured on rx_done_tick and compared to hand values.
module tb_uart_receiver;

    localparam int TickDiv = 27;
    localparam int BitClk  = 16 * TickDiv;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_busy;
    logic       rx_done_tick;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int tick_div = 0;

    // Each entry is {frame_err, data_out} captured during an rx_done_tick cycle.
    logic [8:0] done_q[$];

    uart_receiver #(
        .DATA_BITS    (8),
        .STOP_BIT_TICK(16)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .rx_busy     (rx_busy),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) begin
        if (tick_div == TickDiv - 1) begin
            tick_div    = 0;
            sample_tick = 1'b1;
        end else begin
            tick_div    = tick_div + 1;
            sample_tick = 1'b0;
        end
    end

    always @(negedge clk_50MHz) begin
        if (rx_done_tick === 1'b1) done_q.push_back({frame_err, data_out});
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_50MHz);
    endtask

    // A low stop bit is held only past its midpoint so no extra frame is started.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period);
        rx = 1'b0;
        repeat (period) @(negedge clk_50MHz);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (period) @(negedge clk_50MHz);
        end
        if (stop_bit) begin
            rx = 1'b1;
            repeat (period) @(negedge clk_50MHz);
        end else begin
            rx = 1'b0;
            repeat (period * 5 / 8) @(negedge clk_50MHz);
            rx = 1'b1;
            repeat (period - period * 5 / 8) @(negedge clk_50MHz);
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_50MHz);
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h, expected 00", data_out);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, expected 0", rx_busy);
        end
        checks++;
        if (rx_done_tick !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b, expected 0", rx_done_tick);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr: got %b, expected 0", frame_err);
        end
        reset = 1'b0;
        idle(BitClk);
        checks++;
        if (done_q.size() != 0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_false_start: got %0d done, busy=%b, expected 0 done, busy=0",
                     done_q.size(), rx_busy);
        end
        done_q.delete();
    endtask

    task automatic test_ideal();
        logic [8:0] got;
        fork
            send_frame(8'hA5, 1'b1, BitClk);
            begin
                repeat (BitClk * 3) @(negedge clk_50MHz);
                checks++;
                if (rx_busy !== 1'b1) begin
                    errors++; $display("FAIL ideal_busy_mid: got %b, expected 1", rx_busy);
                end
            end
        join
        idle(BitClk);
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL ideal_count: got %0d done, expected 1", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'hA5}) begin
                errors++; $display("FAIL ideal_frame: got ferr=%b data=%h, expected ferr=0 data=a5",
                                   got[8], got[7:0]);
            end
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL ideal_busy_after: got %b, expected 0", rx_busy);
        end
        done_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        send_frame(8'h00, 1'b1, BitClk);
        send_frame(8'hFF, 1'b1, BitClk);
        idle(BitClk);
        checks++;
        if (done_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d done, expected 2", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'h00}) begin
                errors++; $display("FAIL b2b_first: got ferr=%b data=%h, expected ferr=0 data=00",
                                   got[8], got[7:0]);
            end
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'hFF}) begin
                errors++; $display("FAIL b2b_second: got ferr=%b data=%h, expected ferr=0 data=ff",
                                   got[8], got[7:0]);
            end
        end
        done_q.delete();
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4 * TickDiv) @(negedge clk_50MHz);
        idle(BitClk * 2);
        checks++;
        if (done_q.size() != 0) begin
            errors++; $display("FAIL glitch_done: got %0d done, expected 0", done_q.size());
        end
        checks++;
        if (data_out !== 8'hFF) begin
            errors++; $display("FAIL glitch_data: got %h, expected ff", data_out);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy: got %b, expected 0", rx_busy);
        end
        done_q.delete();
    endtask

    task automatic test_frame_err();
        logic [8:0] got;
        send_frame(8'h3C, 1'b0, BitClk);
        idle(BitClk);
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL ferr_count: got %0d done, expected 1", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b1, 8'h3C}) begin
                errors++; $display("FAIL ferr_frame: got ferr=%b data=%h, expected ferr=1 data=3c",
                                   got[8], got[7:0]);
            end
        end
        done_q.delete();
        send_frame(8'h81, 1'b1, BitClk);
        idle(BitClk);
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL ferr_clear_count: got %0d done, expected 1", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'h81}) begin
                errors++;
                $display("FAIL ferr_clear_frame: got ferr=%b data=%h, expected ferr=0 data=81",
                         got[8], got[7:0]);
            end
        end
        done_q.delete();
    endtask

    task automatic test_reset_abort();
        logic [8:0] got;
        fork
            send_frame(8'h5A, 1'b1, BitClk);
            begin
                // Middle of data bit 3, held until the aborted frame's stop bit.
                repeat (BitClk * 4 + BitClk / 2) @(negedge clk_50MHz);
                reset = 1'b1;
                repeat (10) @(negedge clk_50MHz);
                checks++;
                if (data_out !== 8'h00 || rx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_in_reset: got data=%h busy=%b, expected data=00 busy=0",
                             data_out, rx_busy);
                end
                repeat (BitClk * 5 - 10) @(negedge clk_50MHz);
                reset = 1'b0;
            end
        join
        idle(BitClk);
        checks++;
        if (done_q.size() != 0) begin
            errors++; $display("FAIL abort_done: got %0d done, expected 0", done_q.size());
        end
        done_q.delete();
        send_frame(8'h5A, 1'b1, BitClk);
        idle(BitClk);
        checks++;
        if (done_q.size() != 1) begin
            errors++; $display("FAIL abort_clean_count: got %0d done, expected 1", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'h5A}) begin
                errors++;
                $display("FAIL abort_clean_frame: got ferr=%b data=%h, expected ferr=0 data=5a",
                         got[8], got[7:0]);
            end
        end
        done_q.delete();
    endtask

    task automatic test_baud_drift();
        logic [8:0] got;
        int periods[2] = '{BitClk * 103 / 100, BitClk * 97 / 100};
        for (int p = 0; p < 2; p++) begin
            send_frame(8'h96, 1'b1, periods[p]);
            idle(BitClk);
            checks++;
            if (done_q.size() != 1) begin
                errors++;
                $display("FAIL drift_count[%0d]: got %0d done, expected 1", periods[p], done_q.size());
            end else begin
                got = done_q.pop_front();
                checks++;
                if (got !== {1'b0, 8'h96}) begin
                    errors++;
                    $display("FAIL drift_frame[%0d]: got ferr=%b data=%h, expected ferr=0 data=96",
                             periods[p], got[8], got[7:0]);
                end
            end
            done_q.delete();
        end
    endtask

    // Line low for 10.5 bits: a 0x00 frame with framing error, then an immediate
    // restart that sees the released (high) line as 0xFF with a good stop bit.
    task automatic test_break();
        logic [8:0] got;
        rx = 1'b0;
        repeat (BitClk * 10 + BitClk / 2) @(negedge clk_50MHz);
        idle(BitClk * 11);
        checks++;
        if (done_q.size() != 2) begin
            errors++; $display("FAIL break_count: got %0d done, expected 2", done_q.size());
        end else begin
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b1, 8'h00}) begin
                errors++; $display("FAIL break_first: got ferr=%b data=%h, expected ferr=1 data=00",
                                   got[8], got[7:0]);
            end
            got = done_q.pop_front();
            checks++;
            if (got !== {1'b0, 8'hFF}) begin
                errors++; $display("FAIL break_restart: got ferr=%b data=%h, expected ferr=0 data=ff",
                                   got[8], got[7:0]);
            end
        end
        done_q.delete();
    endtask

    initial begin
        @(negedge clk_50MHz);
        test_reset();
        test_ideal();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_abort();
        test_baud_drift();
        test_break();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
